power_switch_sequencer: RTL and testbench
=========================================

POWER_SWITCH_SEQUENCER -- requirements
Module: power_switch_sequencer

Interface
REQ-001: NUM_DOMAINS, default 4, number of switchable power domains (2..8).
REQ-002: TIMEOUT_CYCLES, default 255, maximum wait for a switch acknowledge (1..255).
REQ-003: clk_i  input  1  sole clock; every flop is clocked on its rising edge.
REQ-004: rst_i  input  1  synchronous, active-high reset.
REQ-005: req_valid_i  input  NUM_DOMAINS  per-domain transition request; the requester holds it until accepted.
REQ-006: req_on_i  input  NUM_DOMAINS  per-domain target state: 1 = on, 0 = off.
REQ-007: req_ready_o  output  NUM_DOMAINS  one-hot, one-cycle acceptance pulse.
REQ-008: switch_en_o  output  NUM_DOMAINS  power-switch enable.
REQ-009: switch_ack_i  input  NUM_DOMAINS  power-switch status: 1 = rail good.
REQ-010: iso_en_o  output  NUM_DOMAINS  isolation clamp enable.
REQ-011: clk_en_o  output  NUM_DOMAINS  domain clock enable.
REQ-012: ret_save_o / ret_restore_o  output  NUM_DOMAINS  one-cycle retention pulses.
REQ-013: domain_on_o  output  NUM_DOMAINS  committed domain state.
REQ-014: busy_o  output  1  high when the state is not IDLE.
REQ-015: done_o  output  1  one-cycle pulse when a transition completes.
REQ-016: error_o  output  1  sticky acknowledge-timeout flag.
REQ-017: err_domain_o  output  3  index of the first domain that timed out.

Function
REQ-018: States: IDLE, CLK_OFF, ISO_ON, SAVE, PWR_OFF, WAIT_OFF, PWR_ON, WAIT_ON, RESTORE, ISO_OFF, CLK_ON, DONE; all outputs are registered.
REQ-019: IDLE arbitration:
- Round-robin grant among pending req_valid_i.
- Search starts at (last granted + 1) mod NUM_DOMAINS; the pointer is 0 after reset.
- The winner's req_ready_o pulses in the acceptance cycle.
- The winner's index and target are latched.
REQ-020: A request whose req_on_i equals the domain's domain_on_o goes IDLE->DONE with no output changes.
REQ-021: Off sequence, one cycle per state: CLK_OFF, ISO_ON, SAVE, PWR_OFF, WAIT_OFF.
- CLK_OFF drops clk_en_o.
- ISO_ON raises iso_en_o.
- SAVE pulses ret_save_o.
- PWR_OFF drops switch_en_o.
- WAIT_OFF holds until switch_ack_i=0, then goes to DONE and clears domain_on_o.
REQ-022: On sequence: PWR_ON, WAIT_ON, RESTORE, ISO_OFF, CLK_ON.
- PWR_ON raises switch_en_o.
- WAIT_ON holds until switch_ack_i=1.
- RESTORE pulses ret_restore_o.
- ISO_OFF drops iso_en_o.
- CLK_ON raises clk_en_o and sets domain_on_o.
- Then DONE.
REQ-023: DONE lasts one cycle, pulses done_o, and returns to IDLE.
REQ-024: WAIT_* timeout:
- An 8-bit counter clears on entry and increments each cycle.
- If the counter reaches TIMEOUT_CYCLES without the acknowledge: set error_o, capture err_domain_o only if error_o was 0, go to DONE, and leave domain_on_o unchanged.
- switch_en_o, iso_en_o and clk_en_o keep their current values, so a failed power-up stays isolated and gated.
REQ-025: The acknowledge is sampled only in the WAIT state; an acknowledge seen in the entry cycle completes that state (minimum 1 cycle).
REQ-026: Exactly one domain is in sequence at a time. Requests arriving while busy_o=1 stay pending. Outputs of non-selected domains never change.
REQ-027: req_valid_i deasserted before its acceptance pulse is a dropped request and is not sequenced.
REQ-028: error_o is cleared only by reset; sequencing continues normally after an error.

Reset
REQ-029: On rst_i=1 at a clock edge:
- state = IDLE and RR pointer = 0.
- switch_en_o, clk_en_o and domain_on_o = all ones.
- iso_en_o, ret_save_o, ret_restore_o, req_ready_o, done_o, busy_o, error_o = 0.
- err_domain_o = 0.
REQ-030: Reset asserted mid-sequence abandons the sequence and forces the REQ-029 values on the next edge, regardless of switch_ack_i.

Configuration
REQ-031: Macro PSEQ_RETENTION_EN defined: the SAVE and RESTORE states exist as in REQ-021/022.
REQ-032: PSEQ_RETENTION_EN undefined:
- ISO_ON goes directly to PWR_OFF, and WAIT_ON goes directly to ISO_OFF.
- ret_save_o and ret_restore_o are constant 0.
- Each sequence is one cycle shorter.

Verification
REQ-033: Domain 1 off, PSEQ_RETENTION_EN defined:
- Stimulus: accept at cycle T; switch_ack_i[1] falls at T+5.
- Response: clk_en_o[1] low at T+1, iso_en_o[1] high at T+2, ret_save_o[1] pulse at T+3, switch_en_o[1] low at T+4, done_o and domain_on_o[1]=0 at T+6.
REQ-034: Simultaneous off requests on domains 0, 2 and 3 after reset.
- Response: grants in order 0, 2, 3.
- A repeated domain-0 request then wins only after domain 3.
REQ-035: Domain 2 power-up, TIMEOUT_CYCLES=4, switch_ack_i[2] held low.
- Response: error_o=1, err_domain_o=2, iso_en_o[2]=1, clk_en_o[2]=0, domain_on_o[2]=0.
- A following domain-0 request still completes.
REQ-036: Request on domain 3 with req_on_i=1 while already on.
- Response: req_ready_o pulse, done_o on the next cycle, no other output changes.
REQ-037: rst_i asserted during WAIT_ON.
- Response: next cycle all outputs match REQ-029 and busy_o=0.
REQ-038: PSEQ_RETENTION_EN undefined, repeat REQ-033.
- Response: switch_en_o[1] low at T+3, no ret_save_o pulse, done_o at T+5 with the acknowledge falling at T+4.

Source files
------------

// File: rtl/power_switch_sequencer.sv
`default_nettype none
// ============================================================================
// power_switch_sequencer: round-robin power-domain on/off sequencer with
// switch-acknowledge timeout. Optional retention states: PSEQ_RETENTION_EN.
// Revision: 1.0
// ============================================================================
module power_switch_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_DOMAINS-1:0] req_valid_i,
  input  logic [NUM_DOMAINS-1:0] req_on_i,
  output logic [NUM_DOMAINS-1:0] req_ready_o,
  output logic [NUM_DOMAINS-1:0] switch_en_o,
  input  logic [NUM_DOMAINS-1:0] switch_ack_i,
  output logic [NUM_DOMAINS-1:0] iso_en_o,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] ret_save_o,
  output logic [NUM_DOMAINS-1:0] ret_restore_o,
  output logic [NUM_DOMAINS-1:0] domain_on_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [2:0]             err_domain_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLK_OFF  = 4'd1;
  localparam logic [3:0] S_ISO_ON   = 4'd2;
  localparam logic [3:0] S_PWR_OFF  = 4'd4;
  localparam logic [3:0] S_WAIT_OFF = 4'd5;
  localparam logic [3:0] S_PWR_ON   = 4'd6;
  localparam logic [3:0] S_WAIT_ON  = 4'd7;
  localparam logic [3:0] S_ISO_OFF  = 4'd9;
  localparam logic [3:0] S_CLK_ON   = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;
`ifdef PSEQ_RETENTION_EN
  localparam logic [3:0] S_SAVE     = 4'd3;
  localparam logic [3:0] S_RESTORE  = 4'd8;
`endif
  localparam logic [7:0]             TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE_HOT0     = {{(NUM_DOMAINS-1){1'b0}}, 1'b1};

  logic [3:0]             state, state_next;
  logic [2:0]             sel, rr_ptr, cand, grant_idx;
  logic                   grant_found, grant_on, grant_cur_on, sel_ack, timeout;
  logic [7:0]             valid_ext, wait_cnt;
  logic [NUM_DOMAINS-1:0] grant_mask, sel_mask;
  logic [NUM_DOMAINS-1:0] ready_d, sw_d, iso_d, clk_d, dom_d;
  logic                   done_d, busy_d, err_d;
  logic [2:0]             errdom_d;

  assign valid_ext    = 8'(req_valid_i);
  assign grant_mask   = ONE_HOT0 << grant_idx;
  assign sel_mask     = ONE_HOT0 << sel;
  assign grant_on     = |(req_on_i & grant_mask);
  assign grant_cur_on = |(domain_on_o & grant_mask);
  assign sel_ack      = |(switch_ack_i & sel_mask);
  assign timeout      = (wait_cnt == TIMEOUT_LAST);

  // Descending scan so the candidate closest to rr_ptr is the last writer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 3'd0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      cand = 3'((int'(rr_ptr) + i) % NUM_DOMAINS);
      if (valid_ext[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          if (grant_on == grant_cur_on) state_next = S_DONE;
          else if (grant_on)            state_next = S_PWR_ON;
          else                          state_next = S_CLK_OFF;
        end
      end
      S_CLK_OFF: state_next = S_ISO_ON;
`ifdef PSEQ_RETENTION_EN
      S_ISO_ON:  state_next = S_SAVE;
      S_SAVE:    state_next = S_PWR_OFF;
      S_RESTORE: state_next = S_ISO_OFF;
`else
      S_ISO_ON:  state_next = S_PWR_OFF;
`endif
      S_PWR_OFF: state_next = S_WAIT_OFF;
      S_WAIT_OFF: begin
        if (!sel_ack || timeout) state_next = S_DONE;
      end
      S_PWR_ON: state_next = S_WAIT_ON;
      S_WAIT_ON: begin
`ifdef PSEQ_RETENTION_EN
        if (sel_ack)      state_next = S_RESTORE;
`else
        if (sel_ack)      state_next = S_ISO_OFF;
`endif
        else if (timeout) state_next = S_DONE;
      end
      S_ISO_OFF: state_next = S_CLK_ON;
      S_CLK_ON:  state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Each state's action lands in the output registers at the edge that leaves it.
  always_comb begin
    ready_d  = '0;
    sw_d     = switch_en_o;
    iso_d    = iso_en_o;
    clk_d    = clk_en_o;
    dom_d    = domain_on_o;
    done_d   = (state == S_DONE);
    busy_d   = (state_next != S_IDLE);
    err_d    = error_o;
    errdom_d = err_domain_o;
    case (state)
      S_IDLE:    if (grant_found) ready_d = grant_mask;
      S_CLK_OFF: clk_d = clk_en_o & ~sel_mask;
      S_ISO_ON:  iso_d = iso_en_o | sel_mask;
      S_PWR_OFF: sw_d  = switch_en_o & ~sel_mask;
      S_PWR_ON:  sw_d  = switch_en_o | sel_mask;
      S_ISO_OFF: iso_d = iso_en_o & ~sel_mask;
      S_CLK_ON: begin
        clk_d = clk_en_o | sel_mask;
        dom_d = domain_on_o | sel_mask;
      end
      S_WAIT_OFF, S_WAIT_ON: begin
        if ((state == S_WAIT_OFF) && !sel_ack) begin
          dom_d = domain_on_o & ~sel_mask;
        end else if (!((state == S_WAIT_ON) && sel_ack) && timeout) begin
          err_d = 1'b1;
          if (!error_o) errdom_d = sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      rr_ptr       <= 3'd0;
      sel          <= 3'd0;
      wait_cnt     <= 8'd0;
      req_ready_o  <= '0;
      switch_en_o  <= '1;
      iso_en_o     <= '0;
      clk_en_o     <= '1;
      domain_on_o  <= '1;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
      err_domain_o <= 3'd0;
    end else begin
      state <= state_next;
      if ((state == S_IDLE) && grant_found) begin
        sel    <= grant_idx;
        rr_ptr <= 3'((int'(grant_idx) + 1) % NUM_DOMAINS);
      end
      wait_cnt     <= ((state == S_WAIT_OFF) || (state == S_WAIT_ON)) ? wait_cnt + 8'd1 : 8'd0;
      req_ready_o  <= ready_d;
      switch_en_o  <= sw_d;
      iso_en_o     <= iso_d;
      clk_en_o     <= clk_d;
      domain_on_o  <= dom_d;
      done_o       <= done_d;
      busy_o       <= busy_d;
      error_o      <= err_d;
      err_domain_o <= errdom_d;
    end
  end

`ifdef PSEQ_RETENTION_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ret_save_o    <= '0;
      ret_restore_o <= '0;
    end else begin
      ret_save_o    <= (state == S_SAVE)    ? sel_mask : '0;
      ret_restore_o <= (state == S_RESTORE) ? sel_mask : '0;
    end
  end
`else
  assign ret_save_o    = '0;
  assign ret_restore_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_power_switch_sequencer.sv
`default_nettype none
// tb_power_switch_sequencer: table-driven off-sequence vectors plus directed
// arbitration, timeout, no-change and mid-sequence reset checks.
module tb_power_switch_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_on, req_ready, switch_en, switch_ack;
  logic [N-1:0] iso_en, clk_en, ret_save, ret_restore, domain_on;
  logic         busy, done, error;
  logic [2:0]   err_domain;
  logic [N-1:0] follow, ack_force;

  int n_checks = 0;
  int n_fail   = 0;

  // Rail model: acknowledge tracks the switch enable unless forced per domain.
  assign switch_ack = (switch_en & follow) | (ack_force & ~follow);

  always #5 clk = ~clk;

  power_switch_sequencer #(.NUM_DOMAINS(N), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_on_i(req_on), .req_ready_o(req_ready),
    .switch_en_o(switch_en), .switch_ack_i(switch_ack),
    .iso_en_o(iso_en), .clk_en_o(clk_en),
    .ret_save_o(ret_save), .ret_restore_o(ret_restore),
    .domain_on_o(domain_on), .busy_o(busy), .done_o(done),
    .error_o(error), .err_domain_o(err_domain)
  );

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] on;
    logic [3:0] ready;
    logic [3:0] clk_en;
    logic [3:0] iso;
    logic [3:0] save;
    logic [3:0] sw;
    logic [3:0] dom;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t tbl [0:7];
  int   nrows;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_switch_en"}, switch_en, 4'hF);
    check({p, "_clk_en"}, clk_en, 4'hF);
    check({p, "_domain_on"}, domain_on, 4'hF);
    check({p, "_iso_en"}, iso_en, 4'h0);
    check({p, "_ret_save"}, ret_save, 4'h0);
    check({p, "_ret_restore"}, ret_restore, 4'h0);
    check({p, "_req_ready"}, req_ready, 4'h0);
    check({p, "_done"}, done, 1'b0);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_error"}, error, 1'b0);
    check({p, "_err_domain"}, err_domain, 3'd0);
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 40 && idx < 0; c++) begin
      tick();
      for (int d = 0; d < N; d++) if (req_ready[d]) idx = d;
    end
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_wait: no req_ready within 40 cycles, valid=0x%0h", req_valid);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      tick();
      if (done) cyc = c;
    end
    if (cyc == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: no done within 40 cycles, busy=%0b", busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int cyc;
    int order [4];
    logic [N-1:0] s_sw, s_iso, s_clk, s_dom;

    //                valid    on       ready    clk_en   iso      save     sw       dom      done  busy
    tbl[0] = {4'b0010, 4'b0000, 4'b0010, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1};
    tbl[1] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1};
    tbl[2] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1};
`ifdef PSEQ_RETENTION_EN
    tbl[3] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0010, 4'b1111, 4'b1111, 1'b0, 1'b1};
    tbl[4] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1111, 1'b0, 1'b1};
    tbl[5] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1101, 1'b0, 1'b1};
    tbl[6] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1101, 1'b1, 1'b0};
    tbl[7] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1101, 1'b0, 1'b0};
    nrows = 8;
`else
    tbl[3] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1111, 1'b0, 1'b1};
    tbl[4] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1101, 1'b0, 1'b1};
    tbl[5] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1101, 1'b1, 1'b0};
    tbl[6] = {4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b1101, 4'b1101, 1'b0, 1'b0};
    tbl[7] = '0;
    nrows = 7;
`endif

    rst = 1'b1; req_valid = '0; req_on = '0; follow = '1; ack_force = '0;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;

    // Domain 1 power-down, one row per cycle starting at the acceptance cycle.
    for (int r = 0; r < nrows; r++) begin
      req_valid = tbl[r].valid;
      req_on    = tbl[r].on;
      tick();
      check($sformatf("off1_r%0d_ready", r), req_ready, tbl[r].ready);
      check($sformatf("off1_r%0d_clk_en", r), clk_en, tbl[r].clk_en);
      check($sformatf("off1_r%0d_iso", r), iso_en, tbl[r].iso);
      check($sformatf("off1_r%0d_save", r), ret_save, tbl[r].save);
      check($sformatf("off1_r%0d_sw", r), switch_en, tbl[r].sw);
      check($sformatf("off1_r%0d_dom", r), domain_on, tbl[r].dom);
      check($sformatf("off1_r%0d_done", r), done, tbl[r].done);
      check($sformatf("off1_r%0d_busy", r), busy, tbl[r].busy);
    end

    // Round-robin: 0,2,3 off together, then a repeat on-request for 0.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1101; req_on = 4'b0000;
    order = '{0, 2, 3, 0};
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check($sformatf("rr_grant%0d", k), g, order[k]);
      if (g >= 0) req_valid[g] = 1'b0;
      if (k == 0) begin
        req_valid[0] = 1'b1;
        req_on[0]    = 1'b1;
      end
    end
    req_valid = '0; req_on = '0;
    wait_done(cyc);
    check("rr_dom", domain_on, 4'b0011);
    check("rr_sw", switch_en, 4'b0011);
    check("rr_clk", clk_en, 4'b0011);
    check("rr_iso", iso_en, 4'b1100);
    check("rr_error", error, 1'b0);

    // Domain 2 power-up with the rail never reporting good.
    follow[2] = 1'b0; ack_force[2] = 1'b0;
    req_valid = 4'b0100; req_on = 4'b0100;
    wait_grant(g);
    req_valid = '0;
    check("to_grant", g, 2);
    wait_done(cyc);
    check("to_latency", cyc, 6);
    check("to_error", error, 1'b1);
    check("to_err_domain", err_domain, 3'd2);
    check("to_iso2", iso_en[2], 1'b1);
    check("to_clk2", clk_en[2], 1'b0);
    check("to_dom2", domain_on[2], 1'b0);
    check("to_sw2", switch_en[2], 1'b1);

    req_valid = 4'b0001; req_on = 4'b0000;
    wait_grant(g);
    req_valid = '0;
    check("post_err_grant", g, 0);
    wait_done(cyc);
    check("post_err_dom", domain_on, 4'b0010);
    check("post_err_error", error, 1'b1);

    // A second timeout must not overwrite the first captured domain.
    follow[3] = 1'b0; ack_force[3] = 1'b0;
    req_valid = 4'b1000; req_on = 4'b1000;
    wait_grant(g);
    req_valid = '0; req_on = '0;
    check("to2_grant", g, 3);
    wait_done(cyc);
    check("to2_err_domain", err_domain, 3'd2);
    check("to2_dom3", domain_on[3], 1'b0);

    // Request matching the current state: accept, then done, nothing else moves.
    s_sw = switch_en; s_iso = iso_en; s_clk = clk_en; s_dom = domain_on;
    req_valid = 4'b0010; req_on = 4'b0010;
    wait_grant(g);
    req_valid = '0; req_on = '0;
    check("same_ready", req_ready, 4'b0010);
    check("same_done_t", done, 1'b0);
    tick();
    check("same_done_t1", done, 1'b1);
    check("same_sw", switch_en, s_sw);
    check("same_iso", iso_en, s_iso);
    check("same_clk", clk_en, s_clk);
    check("same_dom", domain_on, s_dom);
    tick();
    check("same_done_t2", done, 1'b0);

    // Reset while stuck in the power-up wait.
    follow[0] = 1'b0; ack_force[0] = 1'b0;
    req_valid = 4'b0001; req_on = 4'b0001;
    wait_grant(g);
    req_valid = '0; req_on = '0;
    check("rstw_grant", g, 0);
    tick(); tick();
    check("rstw_busy", busy, 1'b1);
    check("rstw_sw0", switch_en[0], 1'b1);
    rst = 1'b1;
    tick();
    check_reset("rst_mid");
    rst = 1'b0;
    follow = '1;

    // A request withdrawn before acceptance is never sequenced.
    req_valid = 4'b0010; req_on = 4'b0000;
    wait_grant(g);
    check("drop_grant", g, 1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_done(cyc);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("drop_ready%0d", c), req_ready, 4'b0000);
    end
    check("drop_dom", domain_on, 4'b1101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
